// File: rtl/softex_pkg.sv
// Shared softex types and floating-point format helpers.
// Format encodings are resolved here so this slice does not depend on fpnew.
package softex_pkg;

  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  localparam fp_format_e FPFORMAT_IN = FP16ALT;

  typedef enum logic {IDLE, ACC} running_max_state_t;

  function automatic int unsigned fp_exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned fp_man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
  endfunction

  // Sign and exponent all ones, mantissa zero; right-aligned in 64 bits.
  function automatic logic [63:0] fp_neg_inf(fp_format_e fmt);
    logic [63:0] ones;
    ones = (64'd1 << (fp_exp_bits(fmt) + 1)) - 64'd1;
    return ones << fp_man_bits(fmt);
  endfunction

  function automatic logic fp_is_nan(fp_format_e fmt, logic [63:0] bits);
    logic [63:0] emask, mmask;
    mmask = (64'd1 << fp_man_bits(fmt)) - 64'd1;
    emask = ((64'd1 << fp_exp_bits(fmt)) - 64'd1) << fp_man_bits(fmt);
    return ((bits & emask) == emask) && ((bits & mmask) != 64'd0);
  endfunction

endpackage

// File: rtl/softex_fp_order_cmp.sv
// Combinational total-order compare of two floats (a > b) plus per-operand NaN flags.
module softex_fp_order_cmp
  import softex_pkg::*;
#(
  parameter fp_format_e FPFORMAT = FPFORMAT_IN,
  localparam int unsigned WIDTH = fp_width(FPFORMAT)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_gt_b_o,
  output logic             a_nan_o,
  output logic             b_nan_o
);

  // Positive values move above all negatives; negatives are inverted so larger magnitude sorts lower.
  function automatic logic [WIDTH-1:0] order_key(logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ~x : {1'b1, x[WIDTH-2:0]};
  endfunction

  assign a_gt_b_o = order_key(a_i) > order_key(b_i);
  assign a_nan_o  = fp_is_nan(FPFORMAT, 64'(a_i));
  assign b_nan_o  = fp_is_nan(FPFORMAT, 64'(b_i));

endmodule

// File: rtl/softex_fp_running_max.sv
// Folds per-beat partial maxima into a running row maximum and emits max/prev/increase per beat.
module softex_fp_running_max
  import softex_pkg::*;
#(
  parameter fp_format_e  FPFORMAT  = FPFORMAT_IN,
  parameter int unsigned LEN_WIDTH = 16,
  localparam int unsigned WIDTH    = fp_width(FPFORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 strb_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     max_o,
  output logic [WIDTH-1:0]     prev_max_o,
  output logic                 inc_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam logic [WIDTH-1:0] NEG_INF = WIDTH'(fp_neg_inf(FPFORMAT));

  running_max_state_t   state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [WIDTH-1:0]     run_q, run_d, max_q, max_d, prev_q, prev_d;
  logic                 valid_q, valid_d, inc_q, inc_d, last_q, last_d;

  logic             d_gt_run, d_nan, run_nan, take, accept, out_free, is_last;
  logic [WIDTH-1:0] cand;

  softex_fp_order_cmp #(.FPFORMAT(FPFORMAT)) i_cmp (
    .a_i      (data_i),
    .b_i      (run_q),
    .a_gt_b_o (d_gt_run),
    .a_nan_o  (d_nan),
    .b_nan_o  (run_nan)
  );

  assign out_free = !valid_q || ready_i;
  assign ready_o  = (state_q == ACC) && enable_i && out_free;
  assign accept   = valid_i && ready_o;
  assign is_last  = (cnt_q == len_q - LEN_WIDTH'(1));
  assign take     = strb_i && !d_nan && (d_gt_run || run_nan);
  assign cand     = take ? data_i : run_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    run_d   = run_q;
    valid_d = valid_q;
    max_d   = max_q;
    prev_d  = prev_q;
    inc_d   = inc_q;
    last_d  = last_q;
    if (enable_i) begin
      if (valid_q && ready_i) valid_d = 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          run_d = NEG_INF;
          cnt_d = '0;
          len_d = len_i;
          if (len_i != '0) begin
            state_d = ACC;
          // An empty row needs the output slot; a blocked slot ignores the start rather than overwrite.
          end else if (out_free) begin
            valid_d = 1'b1;
            max_d   = NEG_INF;
            prev_d  = NEG_INF;
            inc_d   = 1'b0;
            last_d  = 1'b1;
          end
        end
        ACC: if (accept) begin
          valid_d = 1'b1;
          prev_d  = run_q;
          max_d   = cand;
          run_d   = cand;
          inc_d   = take;
          last_d  = is_last;
          cnt_d   = is_last ? '0 : cnt_q + LEN_WIDTH'(1);
          if (is_last) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      run_q   <= NEG_INF;
      valid_q <= 1'b0;
      max_q   <= NEG_INF;
      prev_q  <= NEG_INF;
      inc_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      run_q   <= NEG_INF;
      valid_q <= 1'b0;
      max_q   <= NEG_INF;
      prev_q  <= NEG_INF;
      inc_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      max_q   <= max_d;
      prev_q  <= prev_d;
      inc_q   <= inc_d;
      last_q  <= last_d;
    end
  end

  assign valid_o    = valid_q;
  assign max_o      = max_q;
  assign prev_max_o = prev_q;
  assign inc_o      = inc_q;
  assign last_o     = last_q;
  assign busy_o     = (state_q == ACC) || valid_q;

endmodule

// File: tb/tb_softex_fp_running_max.sv
// Directed bench for softex_fp_running_max in FP16ALT (bfloat16) format.
module tb_softex_fp_running_max;
  import softex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni, clear_i, enable_i, start_i, valid_i, strb_i, ready_i;
  logic [15:0] len_i, data_i;
  logic        ready_o, valid_o, inc_o, last_o, busy_o;
  logic [15:0] max_o, prev_max_o;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [15:0] NINF = 16'hFF80;

  softex_fp_running_max #(.FPFORMAT(FP16ALT), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .start_i(start_i), .len_i(len_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .strb_i(strb_i), .valid_o(valid_o), .ready_i(ready_i),
    .max_o(max_o), .prev_max_o(prev_max_o), .inc_o(inc_o), .last_o(last_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] mx, input logic [15:0] pv,
                          input logic inc, input logic lst);
    chk({tag, "_vld"},  32'(valid_o),    32'd1);
    chk({tag, "_max"},  32'(max_o),      32'(mx));
    chk({tag, "_prev"}, 32'(prev_max_o), 32'(pv));
    chk({tag, "_inc"},  32'(inc_o),      32'(inc));
    chk({tag, "_last"}, 32'(last_o),     32'(lst));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [15:0] l);
    start_i = 1'b1;
    len_i   = l;
    tick;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic s);
    int n;
    n = 0;
    valid_i = 1'b1;
    data_i  = d;
    strb_i  = s;
    #1;
    while (!ready_o && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) chk("send_timeout", 32'd0, 32'd1);
    tick;
    valid_i = 1'b0;
  endtask

  logic [15:0] t4_in  [4];
  logic [15:0] t4_max [4];
  logic [15:0] t4_prv [4];
  logic        t4_inc [4];

  initial begin
    int bi, oi;
    logic did_stall, acc, oh;

    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
    valid_i = 1'b0; strb_i = 1'b0; ready_i = 1'b1; len_i = '0; data_i = '0;
    #12;
    chk("rst_vld",  32'(valid_o),    32'd0);
    chk("rst_max",  32'(max_o),      32'(NINF));
    chk("rst_prev", 32'(prev_max_o), 32'(NINF));
    chk("rst_busy", 32'(busy_o),     32'd0);
    chk("rst_rdy",  32'(ready_o),    32'd0);
    rst_ni = 1'b1;
    tick;

    // Row of 3: monotone rise then repeat.
    start_row(3);
    chk("t1_busy", 32'(busy_o), 32'd1);
    send_beat(16'hBF80, 1'b1); chk_beat("t1_b0", 16'hBF80, NINF,     1'b1, 1'b0);
    send_beat(16'h3F80, 1'b1); chk_beat("t1_b1", 16'h3F80, 16'hBF80, 1'b1, 1'b0);
    send_beat(16'h3F80, 1'b1); chk_beat("t1_b2", 16'h3F80, 16'h3F80, 1'b0, 1'b1);
    tick;
    chk("t1_idle_vld",  32'(valid_o), 32'd0);
    chk("t1_idle_busy", 32'(busy_o),  32'd0);
    chk("t1_idle_rdy",  32'(ready_o), 32'd0);

    // Empty row.
    start_row(0);
    chk_beat("t0_len0", NINF, NINF, 1'b0, 1'b1);
    chk("t0_busy", 32'(busy_o), 32'd1);
    tick;
    chk("t0_drain", 32'(busy_o), 32'd0);

    // NaN ignored; +inf then new row.
    start_row(2);
    send_beat(16'h4000, 1'b1); chk_beat("t2_b0", 16'h4000, NINF,     1'b1, 1'b0);
    send_beat(16'h7FC0, 1'b1); chk_beat("t2_nan", 16'h4000, 16'h4000, 1'b0, 1'b1);
    start_row(1);
    send_beat(16'h7F80, 1'b1); chk_beat("t2_inf", 16'h7F80, NINF,     1'b1, 1'b1);

    // Strobe-off beat and signed zeros.
    start_row(2);
    send_beat(16'h4000, 1'b0); chk_beat("t3_nostrb", NINF,     NINF, 1'b0, 1'b0);
    send_beat(16'h8000, 1'b1); chk_beat("t3_negz",   16'h8000, NINF, 1'b1, 1'b1);
    start_row(2);
    send_beat(16'h8000, 1'b1); chk_beat("t3_negz2", 16'h8000, NINF,     1'b1, 1'b0);
    send_beat(16'h0000, 1'b1); chk_beat("t3_posz",  16'h0000, 16'h8000, 1'b1, 1'b1);
    tick;

    // Continuous input with downstream stall.
    t4_in[0] = 16'h3F80; t4_max[0] = 16'h3F80; t4_prv[0] = NINF;     t4_inc[0] = 1'b1;
    t4_in[1] = 16'h4000; t4_max[1] = 16'h4000; t4_prv[1] = 16'h3F80; t4_inc[1] = 1'b1;
    t4_in[2] = 16'hBF80; t4_max[2] = 16'h4000; t4_prv[2] = 16'h4000; t4_inc[2] = 1'b0;
    t4_in[3] = 16'h4040; t4_max[3] = 16'h4040; t4_prv[3] = 16'h4000; t4_inc[3] = 1'b1;
    start_row(4);
    bi = 0; oi = 0; did_stall = 1'b0;
    ready_i = 1'b1; valid_i = 1'b1; strb_i = 1'b1; data_i = t4_in[0];
    #1;
    for (int cyc = 0; cyc < 40 && oi < 4; cyc++) begin
      if (valid_o && !did_stall) begin
        did_stall = 1'b1;
        ready_i = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
          chk("t4_stall_rdy", 32'(ready_o), 32'd0);
          tick;
          chk("t4_stall_vld", 32'(valid_o), 32'd1);
          chk("t4_stall_max", 32'(max_o),   32'(t4_max[0]));
        end
        ready_i = 1'b1;
        #1;
      end
      acc = valid_i && ready_o;
      oh  = valid_o && ready_i;
      if (oh) begin
        chk_beat($sformatf("t4_o%0d", oi), t4_max[oi], t4_prv[oi], t4_inc[oi], oi == 3);
        oi++;
      end
      tick;
      if (acc) begin
        bi++;
        if (bi < 4) data_i = t4_in[bi];
        else valid_i = 1'b0;
      end
    end
    valid_i = 1'b0;
    chk("t4_outs", 32'(oi), 32'd4);
    chk("t4_ins",  32'(bi), 32'd4);
    tick;
    chk("t4_done", 32'(busy_o), 32'd0);

    // Soft clear mid-row.
    start_row(5);
    send_beat(16'h4000, 1'b1);
    send_beat(16'h4040, 1'b1);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    chk("t5_vld",  32'(valid_o), 32'd0);
    chk("t5_busy", 32'(busy_o),  32'd0);
    chk("t5_max",  32'(max_o),   32'(NINF));
    start_row(1);
    send_beat(16'h3F80, 1'b1); chk_beat("t5_fresh", 16'h3F80, NINF, 1'b1, 1'b1);
    tick;

    // Asynchronous reset mid-row.
    start_row(3);
    send_beat(16'h3F80, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_vld",  32'(valid_o),    32'd0);
    chk("t6_max",  32'(max_o),      32'(NINF));
    chk("t6_prev", 32'(prev_max_o), 32'(NINF));
    chk("t6_inc",  32'(inc_o),      32'd0);
    chk("t6_busy", 32'(busy_o),     32'd0);
    chk("t6_rdy",  32'(ready_o),    32'd0);
    #3 rst_ni = 1'b1;
    tick;

    // Global stall mid-row.
    start_row(3);
    send_beat(16'h3F80, 1'b1); chk_beat("t7_b0", 16'h3F80, NINF, 1'b1, 1'b0);
    enable_i = 1'b0;
    valid_i = 1'b1; data_i = 16'h4000; strb_i = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("t7_rdy", 32'(ready_o), 32'd0);
      tick;
      chk("t7_vld", 32'(valid_o), 32'd1);
      chk("t7_max", 32'(max_o),   32'h3F80);
    end
    enable_i = 1'b1;
    valid_i = 1'b0;
    send_beat(16'h4000, 1'b1); chk_beat("t7_b1", 16'h4000, 16'h3F80, 1'b1, 1'b0);
    send_beat(16'hBF80, 1'b1); chk_beat("t7_b2", 16'h4000, 16'h4000, 1'b0, 1'b1);
    tick;
    chk("t7_done", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/softex_fp_running_max.md
Name: softex_fp_running_max

Overview:
- Downstream consumer of the vector min/max reduction stage. Takes one reduced partial maximum per beat and folds it into a running row maximum over a programmed number of beats.
- For every accepted beat it emits the updated maximum, the previous maximum and a "max increased" flag. The online-softmax accumulator uses these to rescale its partial denominator.
- Also signals the last beat of a row so the final maximum can be latched by the normaliser.

Parameters:
- FPFORMAT, softex_pkg FPFORMAT_IN, floating-point format of data.
- LEN_WIDTH, 16, width of row length (beat count).
- WIDTH, localparam = fpnew_pkg::fp_width(FPFORMAT).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear.
- enable_i  in  1  global stall; 0 freezes all state.
- start_i  in  1  row start pulse, sampled only in IDLE.
- len_i  in  LEN_WIDTH  beats in row, latched on start_i.
- valid_i  in  1  partial max valid (from reduction stage).
- ready_o  out  1  partial max accepted.
- data_i  in  WIDTH  partial max value.
- strb_i  in  1  partial max is meaningful (0 = beat counted, value ignored).
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- max_o  out  WIDTH  running max after this beat.
- prev_max_o  out  WIDTH  running max before this beat.
- inc_o  out  1  max_o strictly greater than prev_max_o.
- last_o  out  1  beat is final beat of row.
- busy_o  out  1  state is ACC or output still pending.

Behaviour:
- Reset (rst_ni=0, async):
  - State IDLE; counter 0; running max = -inf (sign=1, exp all ones, mantissa 0).
  - valid_o=0, max_o=prev_max_o=-inf, inc_o=0, last_o=0, busy_o=0, ready_o=0.
- clear_i=1 (sync, priority over everything but reset): same values as reset on the next edge. An in-flight output beat is dropped.
- enable_i=0: no register updates. ready_o forced 0. valid_o and output data hold.
- FSM states:
  - IDLE → ACC on start_i with len_i>0.
  - start_i with len_i=0: emits one output beat with max=prev=-inf, inc=0, last=1, and stays IDLE.
  - ACC → IDLE on acceptance of beat number len-1.
  - start_i in ACC is ignored.
  - On start, the running max is reset to -inf.
- Handshake:
  - Single output register.
  - ready_o = (state==ACC) && enable_i && (!valid_o || ready_i).
  - Input is accepted when valid_i && ready_o.
  - valid_o rises the cycle after acceptance (latency 1) and holds with stable data until ready_i.
  - Simultaneous output handshake and new acceptance gives back-to-back beats (throughput 1/cycle).
- Update on accepted beat:
  - If strb_i=1 and data_i is not NaN, cand = max(run, data_i); otherwise cand = run.
  - prev_max_o <= run; max_o <= cand; run <= cand.
  - inc_o <= (cand > run).
  - last_o <= (counter == len-1).
  - Counter increments and wraps to 0 on last.
- Comparison uses a total-order key, without fpnew:
  - If sign=0: key = x with MSB set.
  - If sign=1: key = ~x.
  - Compare keys unsigned. Consequences: +0 > -0; +inf is largest; -inf is smallest.
  - NaN is any value with exp all ones and mantissa ≠ 0. It never updates the max.
- busy_o = (state==ACC) || valid_o.
- Counter is LEN_WIDTH bits. Maximum row length is 2^LEN_WIDTH-1.

Decomposition:
- softex_pkg gains:
  - running_max_state_t enum {IDLE, ACC}.
  - Function fp_neg_inf(fp_format_e) returning the -inf encoding.
  - Function fp_is_nan(fp_format_e, bits).
- One sub-module: softex_fp_order_cmp. It is combinational and takes (a, b) → a_gt_b, with the NaN flag per operand. The reduction tree can reuse it later.

Test Plan (FPFORMAT=FP16ALT: 1.0=3F80, 2.0=4000, -1.0=BF80, -inf=FF80, NaN=7FC0):
- start len=3; beats BF80, 3F80, 3F80 with ready_i=1 → outputs (max,prev,inc,last) = (BF80,FF80,1,0), (3F80,BF80,1,0), (3F80,3F80,0,1). Beats are 1 cycle after each accept; state back to IDLE.
- len=2; beats 4000 (strb=1), 7FC0 (strb=1), then a new row of len=1 with 7F80 → row 1 outputs 4000 then 4000 with inc=0 and last=1. Row 2 outputs max=7F80, prev=FF80, inc=1, last=1.
- len=2; beat 0 has strb=0 with data 4000 → max stays FF80, inc=0. Beat 1 is 8000 (-0) → max 8000, inc=1. Check 0000 after 8000 in a later row gives inc=1.
- len=4 with valid_i always high; ready_i held low for 3 cycles after the first output → valid_o and data stable, ready_o=0 during the stall. No beats are lost or duplicated; all 4 outputs appear in order.
- Mid-row: clear_i after 2 of 5 beats → next cycle valid_o=0, busy_o=0, IDLE. A fresh start len=1 with 3F80 gives prev=FF80.
- Mid-row: rst_ni low asynchronously → outputs reach reset values without a clock edge. Separately, enable_i=0 for 5 cycles mid-row → no state change, ready_o=0, and the row resumes correctly.
